// File: rtl/key_event_gen.sv
// rtl/key_event_gen.sv - press/release/short/long/auto-repeat event generator for a clean key level
module key_event_gen #(
    parameter int LONG_CNT   = 50000000,
    parameter int REPEAT_CNT = 10000000,
    parameter int CNT_W      = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic key_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_tick,
    output logic held
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LONG = 2'd2
    } state_t;

    // Terminal counter values: the counter runs 0..TC, so it never exceeds max(LONG_CNT, REPEAT_CNT)-1.
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CNT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_q, key_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    // Next-state, counter and registered-output decode; release always takes priority over terminal count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_d     = key_in;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        held_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (key_in && !key_q) begin
                    state_d = HOLD;
                    press_d = 1'b1;
                    held_d  = 1'b1;
                end
            end
            HOLD: begin
                if (!key_in) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                end else if (cnt_q == LONG_TC) begin
                    state_d = LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                    held_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    held_d = 1'b1;
                end
            end
            LONG: begin
                if (!key_in) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == REPEAT_TC) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                    held_d   = 1'b1;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    held_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, key history and output registers; key history resets high so a held key is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_q     <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_press   = short_q;
    assign long_press    = long_q;
    assign repeat_tick   = repeat_q;
    assign held          = held_q;

endmodule

// File: tb/tb_key_event_gen.sv
// tb/tb_key_event_gen.sv - directed self-checking bench for key_event_gen (LONG_CNT=8, REPEAT_CNT=4)
`timescale 1ns/1ps
module tb_key_event_gen;

    logic clk = 1'b0;
    logic reset;
    logic key_in;
    logic press_pulse, release_pulse, short_press, long_press, repeat_tick, held;

    int errors = 0;
    int checks = 0;

    // Per-cycle output history, bit k = cycle P+k; index 0 press, 1 release, 2 short, 3 long, 4 repeat, 5 held.
    logic [63:0] obs [6];
    string       names [6] = '{"press_pulse", "release_pulse", "short_press",
                               "long_press", "repeat_tick", "held"};

    key_event_gen #(
        .LONG_CNT  (8),
        .REPEAT_CNT(4),
        .CNT_W     (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_in       (key_in),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_tick  (repeat_tick),
        .held         (held)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        key_in = 1'b0;
        repeat (n) step();
    endtask

    // pat[k] is the key level sampled at edge k; edge 0 is the press edge, so outputs at bit k are cycle P+k.
    task automatic run_pat(input logic [63:0] pat, input int n);
        for (int i = 0; i < 6; i++) obs[i] = '0;
        key_in = pat[0];
        for (int k = 0; k < n; k++) begin
            step();
            obs[0][k] = press_pulse;
            obs[1][k] = release_pulse;
            obs[2][k] = short_press;
            obs[3][k] = long_press;
            obs[4][k] = repeat_tick;
            obs[5][k] = held;
            key_in = pat[k+1];
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        key_in = 1'b0;
        step();
        step();
        checks++;
        if ({press_pulse, release_pulse, short_press, long_press, repeat_tick, held} !== 6'b0) begin
            errors++;
            $display("FAIL reset.outputs got %b want 000000",
                     {press_pulse, release_pulse, short_press, long_press, repeat_tick, held});
        end
        reset = 1'b0;
        step();
        checks++;
        if ({press_pulse, release_pulse, short_press, long_press, repeat_tick, held} !== 6'b0) begin
            errors++;
            $display("FAIL reset.idle got %b want 000000",
                     {press_pulse, release_pulse, short_press, long_press, repeat_tick, held});
        end
    endtask

    task automatic test_single_sample();
        logic [63:0] ex [6];
        ex = '{64'h1, 64'h2, 64'h2, 64'h0, 64'h0, 64'h1};
        run_pat(64'h1, 4);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== ex[i]) begin
                errors++;
                $display("FAIL single.%s got %h want %h", names[i], obs[i], ex[i]);
            end
        end
        settle(3);
    endtask

    task automatic test_short_press();
        logic [63:0] ex [6];
        ex = '{64'h1, 64'h20, 64'h20, 64'h0, 64'h0, 64'h1F};
        run_pat(64'h1F, 10);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== ex[i]) begin
                errors++;
                $display("FAIL short.%s got %h want %h", names[i], obs[i], ex[i]);
            end
        end
        settle(3);
    endtask

    task automatic test_boundary_short();
        logic [63:0] ex [6];
        ex = '{64'h1, 64'h100, 64'h100, 64'h0, 64'h0, 64'hFF};
        run_pat(64'hFF, 12);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== ex[i]) begin
                errors++;
                $display("FAIL boundary_short.%s got %h want %h", names[i], obs[i], ex[i]);
            end
        end
        settle(3);
    endtask

    task automatic test_boundary_long();
        logic [63:0] ex [6];
        ex = '{64'h1, 64'h200, 64'h0, 64'h100, 64'h0, 64'h1FF};
        run_pat(64'h1FF, 12);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== ex[i]) begin
                errors++;
                $display("FAIL boundary_long.%s got %h want %h", names[i], obs[i], ex[i]);
            end
        end
        settle(3);
    endtask

    task automatic test_long_repeat();
        logic [63:0] ex [6];
        ex = '{64'h1, 64'h100000, 64'h0, 64'h100, 64'h11000, 64'hFFFFF};
        run_pat(64'hFFFFF, 24);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== ex[i]) begin
                errors++;
                $display("FAIL long.%s got %h want %h", names[i], obs[i], ex[i]);
            end
        end
        settle(3);
    endtask

    task automatic test_back_to_back();
        logic [63:0] ex [6];
        ex = '{64'h11, 64'h48, 64'h48, 64'h0, 64'h0, 64'h37};
        run_pat(64'h37, 10);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== ex[i]) begin
                errors++;
                $display("FAIL b2b.%s got %h want %h", names[i], obs[i], ex[i]);
            end
        end
        settle(3);
    endtask

    task automatic test_reset_mid_long();
        logic any_evt;
        run_pat(64'hFFFF, 12);
        checks++;
        if (obs[3] !== 64'h100) begin
            errors++;
            $display("FAIL rst_long.entry got %h want %h", obs[3], 64'h100);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({press_pulse, release_pulse, short_press, long_press, repeat_tick, held} !== 6'b0) begin
            errors++;
            $display("FAIL rst_long.outputs got %b want 000000",
                     {press_pulse, release_pulse, short_press, long_press, repeat_tick, held});
        end
        any_evt = 1'b0;
        repeat (6) begin
            step();
            any_evt = any_evt | press_pulse | release_pulse | short_press
                              | long_press | repeat_tick | held;
        end
        checks++;
        if (any_evt !== 1'b0) begin
            errors++;
            $display("FAIL rst_long.held_key got %b want 0", any_evt);
        end
        key_in = 1'b0;
        step();
        key_in = 1'b1;
        step();
        checks++;
        if ({press_pulse, held} !== 2'b11) begin
            errors++;
            $display("FAIL rst_long.repress got %b want 11", {press_pulse, held});
        end
        settle(4);
    endtask

    initial begin
        reset  = 1'b1;
        key_in = 1'b0;
        test_reset();
        settle(2);
        test_single_sample();
        test_short_press();
        test_boundary_short();
        test_boundary_long();
        test_long_repeat();
        test_back_to_back();
        test_reset_mid_long();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
